// File: rtl/uart_ram_loader.sv
// UART 8N1 receiver that packs four bytes little-endian into 32-bit words and
// streams them to consecutive RAM word addresses through a one-cycle write strobe.
module uart_ram_loader #(
   parameter int          WIDTH    = 32,
   parameter int          CLKDIV   = 434,
   parameter int unsigned BASEADDR = 0,
   parameter int unsigned DEPTH    = 411700
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             datai,
   output logic             wram,
   output logic [WIDTH-1:0] ramaddress,
   output logic [WIDTH-1:0] wramdata,
   output logic             done,
   output logic             frameerr
);

   localparam int CW = $clog2(CLKDIV);

   localparam logic [CW-1:0] FULL_BIT = CW'(CLKDIV - 1);
   localparam logic [CW-1:0] HALF_BIT = CW'(CLKDIV / 2 - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_STOP  = 3'd3;
   localparam logic [2:0] S_BREAK = 3'd4;

   logic          meta;
   logic          rx;
   logic [2:0]    state;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;
   logic [1:0]    lane;
   logic [31:0]   word_buf;
   logic [31:0]   index;

   // NOTE: both synchroniser flops reset to 1 so that leaving reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         meta <= 1'b1;
         rx   <= 1'b1;
      end else begin
         meta <= datai;
         rx   <= meta;
      end
   end

   // NOTE: every register here is sequential state, so only non-blocking assignments are used;
   // later assignments to wram/ramaddress in the same edge override the pulse-retire defaults.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state      <= S_IDLE;
         cnt        <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         lane       <= '0;
         word_buf   <= '0;
         index      <= '0;
         wram       <= 1'b0;
         ramaddress <= WIDTH'(BASEADDR);
         wramdata   <= '0;
         done       <= 1'b0;
         frameerr   <= 1'b0;
      end else begin
         // Retire a write pulse: advance to the next word address.
         if (wram) begin
            wram       <= 1'b0;
            index      <= index + 32'd1;
            ramaddress <= WIDTH'(BASEADDR + index + 32'd1);
            if (index + 32'd1 == DEPTH)
               done <= 1'b1;
         end

         case (state)
            S_IDLE: begin
               if (!rx) begin
                  cnt   <= HALF_BIT;
                  state <= S_START;
               end
            end
            S_START: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else if (rx) begin
                  state <= S_IDLE;
               end else begin
                  cnt     <= FULL_BIT;
                  bit_cnt <= '0;
                  state   <= S_DATA;
               end
            end
            S_DATA: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  shreg   <= {rx, shreg[7:1]};
                  cnt     <= FULL_BIT;
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == 3'd7)
                     state <= S_STOP;
               end
            end
            S_STOP: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else if (rx) begin
                  state                       <= S_IDLE;
                  lane                        <= lane + 1'b1;
                  word_buf[{lane, 3'b000} +: 8] <= shreg;
                  if (lane == 2'd3 && !done) begin
                     wram     <= 1'b1;
                     wramdata <= WIDTH'({shreg, word_buf[23:0]});
                  end
               end else begin
                  frameerr <= 1'b1;
                  state    <= S_BREAK;
               end
            end
            S_BREAK: begin
               if (rx)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_ram_loader.sv
// Directed bench for uart_ram_loader with CLKDIV=16, BASEADDR=100, DEPTH=2;
// a monitor logs every write strobe and the stimulus checks the log against hand-computed words.
module tb_uart_ram_loader;

   localparam int CLKDIV = 16;
   localparam int PERIOD = 10;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        datai = 1'b1;
   logic        wram;
   logic [31:0] ramaddress;
   logic [31:0] wramdata;
   logic        done;
   logic        frameerr;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] w_addr[$];
   logic [31:0] w_data[$];
   time         w_time[$];
   int          wide_pulses = 0;
   logic        prev_wram = 1'b0;
   time         stop_t = 0;

   uart_ram_loader #(
      .WIDTH(32), .CLKDIV(CLKDIV), .BASEADDR(100), .DEPTH(2)
   ) dut (
      .clk(clk), .nrst(nrst), .datai(datai), .wram(wram),
      .ramaddress(ramaddress), .wramdata(wramdata), .done(done), .frameerr(frameerr)
   );

   always #(PERIOD / 2) clk = ~clk;

   // Write-port monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (wram === 1'b1) begin
         w_addr.push_back(ramaddress);
         w_data.push_back(wramdata);
         w_time.push_back($time);
         if (prev_wram === 1'b1)
            wide_pulses++;
      end
      prev_wram = wram;
   end

   initial begin
      #(200000 * PERIOD);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      datai = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
      datai = 1'b0;
      repeat (CLKDIV) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         datai = b[i];
         repeat (CLKDIV) @(negedge clk);
      end
      stop_t = $time;
      datai  = stop_bit;
      repeat (CLKDIV) @(negedge clk);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      nrst = 1'b0;
      @(negedge clk);
      nrst = 1'b1;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_wram"}, {31'd0, wram}, 32'd0);
      check({tag, "_addr"}, ramaddress, 32'd100);
      check({tag, "_wdata"}, wramdata, 32'd0);
      check({tag, "_done"}, {31'd0, done}, 32'd0);
      check({tag, "_frameerr"}, {31'd0, frameerr}, 32'd0);
   endtask

   task automatic clear_log();
      w_addr.delete();
      w_data.delete();
      w_time.delete();
   endtask

   initial begin
      logic [31:0] lat;

      // Power-on reset
      nrst  = 1'b0;
      datai = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_values("por");
      nrst = 1'b1;
      idle(5);

      // 1: single word, latency from the fourth stop bit
      send_byte(8'h78);
      send_byte(8'h56);
      send_byte(8'h34);
      send_byte(8'h12);
      idle(4);
      check("t1_count", w_addr.size(), 32'd1);
      if (w_addr.size() >= 1) begin
         check("t1_addr", w_addr[0], 32'd100);
         check("t1_data", w_data[0], 32'h12345678);
         // Stop bit sampled ~10 clks into the bit (2 sync + CLKDIV/2, +/-1), strobe one clk later.
         lat = 32'((w_time[0] - stop_t) / PERIOD);
         check("t1_latency_ok", {31'd0, (lat >= 32'd10 && lat <= 32'd12)}, 32'd1);
      end
      check("t1_addr_after", ramaddress, 32'd101);
      check("t1_wdata_hold", wramdata, 32'h12345678);
      check("t1_done", {31'd0, done}, 32'd0);
      clear_log();

      // 2: eight bytes back-to-back fill DEPTH
      pulse_reset();
      idle(2);
      for (int i = 0; i < 8; i++)
         send_byte(8'(i));
      idle(4);
      check("t2_count", w_addr.size(), 32'd2);
      if (w_addr.size() >= 2) begin
         check("t2_addr0", w_addr[0], 32'd100);
         check("t2_data0", w_data[0], 32'h03020100);
         check("t2_addr1", w_addr[1], 32'd101);
         check("t2_data1", w_data[1], 32'h07060504);
      end
      check("t2_done", {31'd0, done}, 32'd1);
      check("t2_addr_after", ramaddress, 32'd102);
      clear_log();

      // 3: writes suppressed once done
      send_byte(8'hA1);
      send_byte(8'hB2);
      send_byte(8'hC3);
      send_byte(8'hD4);
      idle(4);
      check("t3_count", w_addr.size(), 32'd0);
      check("t3_addr", ramaddress, 32'd102);
      check("t3_done", {31'd0, done}, 32'd1);
      clear_log();

      // 4: 5-clk glitch on the line is rejected in START
      pulse_reset();
      idle(2);
      datai = 1'b0;
      repeat (5) @(negedge clk);
      idle(40);
      check("t4_count", w_addr.size(), 32'd0);
      check("t4_frameerr", {31'd0, frameerr}, 32'd0);
      check("t4_addr", ramaddress, 32'd100);

      // 5: framing error, break, then a clean word (lane must still be 0)
      send_byte(8'hAA, 1'b0);
      datai = 1'b0;
      repeat (40) @(negedge clk);
      idle(20);
      check("t5_frameerr", {31'd0, frameerr}, 32'd1);
      check("t5_count_bad", w_addr.size(), 32'd0);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      send_byte(8'h44);
      idle(4);
      check("t5_count", w_addr.size(), 32'd1);
      if (w_addr.size() >= 1) begin
         check("t5_addr", w_addr[0], 32'd100);
         check("t5_data", w_data[0], 32'h44332211);
      end
      check("t5_frameerr_sticky", {31'd0, frameerr}, 32'd1);
      clear_log();

      // 6: reset mid-word discards the partial bytes
      pulse_reset();
      idle(2);
      send_byte(8'hDE);
      send_byte(8'hAD);
      pulse_reset();
      check_reset_values("t6_rst");
      idle(2);
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h03);
      send_byte(8'h04);
      idle(4);
      check("t6_count", w_addr.size(), 32'd1);
      if (w_addr.size() >= 1) begin
         check("t6_addr", w_addr[0], 32'd100);
         check("t6_data", w_data[0], 32'h04030201);
      end
      check("t6_addr_after", ramaddress, 32'd101);

      check("strobe_width", 32'(wide_pulses), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
